// File: rtl/handshake_rr_ctrl_arbiter.sv
// Round-robin arbiter for control tokens. Each cycle it grants the first valid
// requester at or after the priority pointer, with wrap-around. The winner's index
// goes into a one-slot output register and is presented as a handshake token.
// A token may be emitted and a new one accepted in the same cycle, so the arbiter
// can pass one token per cycle.
module handshake_rr_ctrl_arbiter #(
  parameter int NUM_INPUTS  = 4,
  parameter int INDEX_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_INPUTS-1:0]  ins_valid,
  output logic [NUM_INPUTS-1:0]  ins_ready,
  output logic [INDEX_WIDTH-1:0] index,
  output logic                   index_valid,
  input  logic                   index_ready
);

  logic                   full_r;
  logic [INDEX_WIDTH-1:0] idx_r;
  logic [INDEX_WIDTH-1:0] ptr_r;

  logic                   found_s;
  logic [INDEX_WIDTH-1:0] gnt_idx_s;
  logic                   slot_free_s;
  logic                   accept_s;
  logic                   emit_s;
  logic [INDEX_WIDTH-1:0] ptr_next_s;

  // Winner search: first pass covers indices at or above the pointer, second pass wraps to the bottom
  always_comb begin
    found_s   = 1'b0;
    gnt_idx_s = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (!found_s && ins_valid[i] && (INDEX_WIDTH'(i) >= ptr_r)) begin
        found_s   = 1'b1;
        gnt_idx_s = INDEX_WIDTH'(i);
      end else begin
      end
    end
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (!found_s && ins_valid[i]) begin
        found_s   = 1'b1;
        gnt_idx_s = INDEX_WIDTH'(i);
      end else begin
      end
    end
  end

  // The slot can take a token when it is empty or is being drained this cycle
  assign slot_free_s = ~full_r | index_ready;
  // No transfer happens while reset is held, so the ready lines stay low during reset
  assign accept_s    = rst & found_s & slot_free_s;
  assign emit_s      = full_r & index_ready;
  assign ptr_next_s  = (gnt_idx_s == INDEX_WIDTH'(NUM_INPUTS - 1)) ? '0
                                                                  : gnt_idx_s + INDEX_WIDTH'(1);

  // Only the winner sees ready; it depends on the grant and the slot state, never on other readies
  always_comb begin
    ins_ready = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (accept_s && (gnt_idx_s == INDEX_WIDTH'(i))) begin
        ins_ready[i] = 1'b1;
      end else begin
        ins_ready[i] = 1'b0;
      end
    end
  end

  // Slot occupancy, stored index and priority pointer; reset drops any held token
  always_ff @(posedge clk) begin
    if (!rst) begin
      full_r <= 1'b0;
      idx_r  <= '0;
      ptr_r  <= '0;
    end else if (accept_s) begin
      full_r <= 1'b1;
      idx_r  <= gnt_idx_s;
      ptr_r  <= ptr_next_s;
    end else if (emit_s) begin
      full_r <= 1'b0;
    end else begin
      full_r <= full_r;
    end
  end

  assign index       = idx_r;
  assign index_valid = full_r;

endmodule

// File: tb/tb_handshake_rr_ctrl_arbiter.sv
// Scoreboard bench for handshake_rr_ctrl_arbiter. The stimulus side keeps a
// behavioural model of the arbiter. On each accept it pushes the expected index
// into a queue. A separate monitor compares the ready lines and the slot outputs
// every cycle. It also pops and checks one expected index whenever the output
// handshake fires.
module tb_handshake_rr_ctrl_arbiter;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] ins_valid;
  logic [N-1:0] ins_ready;
  logic [1:0]   index;
  logic         index_valid;
  logic         index_ready;

  handshake_rr_ctrl_arbiter #(.NUM_INPUTS(N), .INDEX_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .index(index), .index_valid(index_valid), .index_ready(index_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // model state
  bit       m_full = 1'b0;
  int       m_idx  = 0;
  int       m_ptr  = 0;
  int       sb[$];
  // per-cycle expectations
  logic [N-1:0] exp_ready;
  bit           exp_valid;
  int           exp_idx;

  // Apply one cycle of inputs, predict the outputs and advance the model
  task automatic cyc(input bit r, input logic [N-1:0] v, input bit rdy);
    int  w;
    bit  free;
    bit  acc;
    bit  emit;
    if (!r) rdy = 1'b0;
    rst = r; ins_valid = v; index_ready = rdy;
    exp_valid = m_full;
    exp_idx   = m_idx;
    w = -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (w < 0 && v[c]) w = c;
    end
    if (!r) begin
      exp_ready = '0;
      m_full = 1'b0; m_idx = 0; m_ptr = 0;
      sb.delete();
    end else begin
      free = !m_full || rdy;
      acc  = (w >= 0) && free;
      emit = m_full && rdy;
      exp_ready = acc ? N'(1 << w) : '0;
      if (acc) begin
        sb.push_back(w);
        m_full = 1'b1; m_idx = w; m_ptr = (w + 1) % N;
      end else if (emit) begin
        m_full = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: checks the outputs mid-cycle and pops the scoreboard on each output transfer
  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (ins_ready !== exp_ready) begin
        bad++;
        $display("FAIL ins_ready: got %b want %b at %0t", ins_ready, exp_ready, $time);
      end
      total++;
      if (index_valid !== exp_valid) begin
        bad++;
        $display("FAIL index_valid: got %b want %b at %0t", index_valid, exp_valid, $time);
      end
      total++;
      if (index !== 2'(exp_idx)) begin
        bad++;
        $display("FAIL index_hold: got %0d want %0d at %0t", index, exp_idx, $time);
      end
      if (rst && index_valid === 1'b1 && index_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL token: got %0d want none at %0t", index, $time);
        end else begin
          int e;
          e = sb.pop_front();
          if (index !== 2'(e)) begin
            bad++;
            $display("FAIL token: got %0d want %0d at %0t", index, e, $time);
          end
        end
      end
    end
  end

  initial begin
    // T1: reset held with all requesters valid
    cyc(1'b0, 4'b1111, 1'b1);
    chk_en = 1'b1;
    cyc(1'b0, 4'b1111, 1'b1);
    // T2: rotation, one token per cycle
    for (int i = 0; i < 9; i++) cyc(1'b1, 4'b1111, 1'b1);
    // T3: move pointer to 3, then skip and wrap with 0101
    cyc(1'b1, 4'b0100, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'b0101, 1'b1);
    // T4: hold index 1 under backpressure, then emit 1 and accept 2 together
    cyc(1'b1, 4'b0000, 1'b1);
    cyc(1'b1, 4'b0010, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 4'b1111, 1'b0);
    cyc(1'b1, 4'b1111, 1'b1);
    cyc(1'b1, 4'b0000, 1'b1);
    // T5: single requester
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'b0100, 1'b1);
    cyc(1'b1, 4'b0000, 1'b1);
    // T6: reset while holding index 3
    cyc(1'b1, 4'b1000, 1'b0);
    cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b0, 4'b1111, 1'b1);
    cyc(1'b1, 4'b0000, 1'b1);
    cyc(1'b1, 4'b1111, 1'b1);
    // random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      bit          r;
      logic [N-1:0] v;
      bit          rdy;
      r   = ($urandom_range(0, 63) != 0);
      v   = ($urandom_range(0, 7) == 0) ? 4'b1111 : 4'($urandom_range(0, 15));
      rdy = ($urandom_range(0, 3) != 0);
      cyc(r, v, rdy);
    end
    cyc(1'b1, 4'b0000, 1'b1);
    cyc(1'b1, 4'b0000, 1'b1);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
